pipeline_hazard_ctrl: RTL and testbench



---
 rtl/pipe_pkg.sv | 21 ++
 rtl/sat_counter.sv | 33 +++
 rtl/pipeline_hazard_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// +----------------------------------------------------------------------------+
// | pipe_pkg : shared constants and state encoding for the pipeline controls   |
// | Rev 1.0  : initial release                                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

package pipe_pkg;

  localparam int REG_ADDR_W = 4;

  // Register 0 is hardwired to zero, so it never carries a real dependency.
  localparam logic [REG_ADDR_W-1:0] c_ZERO_REG = '0;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } ctrl_state_e;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// +----------------------------------------------------------------------------+
// | sat_counter : increment-only counter that holds at all-ones                |
// | Rev 1.0     : initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] c_MAX = '1;
  localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && (r_count != c_MAX)) begin
      r_count <= r_count + c_ONE;
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// +----------------------------------------------------------------------------+
// | pipeline_hazard_ctrl : stall/flush sequencer for the 5-stage pipeline      |
// | Rev 1.0              : initial release                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] if_id_rn,
  input  logic [REG_ADDR_W-1:0] if_id_rm,
  input  logic                  if_id_rn_vld,
  input  logic                  if_id_rm_vld,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic                  id_ex_mem_read,
  input  logic                  ex_mem_mem_rd,
  input  logic                  ex_mem_mem_wr,
  input  logic                  ex_mem_br_taken,
  input  logic                  dmem_ack,
  output logic                  dmem_req,
  output logic                  pc_en,
  output logic                  pc_sel_branch,
  output logic                  if_id_en,
  output logic                  if_id_flush,
  output logic                  id_ex_en,
  output logic                  id_ex_flush,
  output logic                  ex_mem_en,
  output logic                  ex_mem_flush,
  output logic                  mem_wb_flush,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic                  mem_timeout,
  output logic                  ctrl_state
);

  localparam int                 c_TMR_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [c_TMR_W-1:0] c_TMO_MAX  = c_TMR_W'(MEM_TIMEOUT);
  localparam logic [c_TMR_W-1:0] c_TMO_LAST = c_TMR_W'(MEM_TIMEOUT - 1);
  localparam logic [c_TMR_W-1:0] c_TMR_ONE  = c_TMR_W'(1);

  ctrl_state_e        r_state;
  ctrl_state_e        w_state_nxt;
  logic [c_TMR_W-1:0] r_timer;
  logic               r_mem_timeout;

  logic w_mem_op;
  logic w_mem_stall;
  logic w_load_use;
  logic w_redirect;
  logic w_lu_stall;

  assign w_mem_op = ex_mem_mem_rd | ex_mem_mem_wr;

  assign w_load_use = id_ex_mem_read && (id_ex_rd != c_ZERO_REG) &&
                      ((if_id_rn_vld && (if_id_rn == id_ex_rd)) ||
                       (if_id_rm_vld && (if_id_rm == id_ex_rd)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Branch and load-use are resolved on any cycle the memory is not stalling,
  // including the ack cycle, so an illegal mem+branch slot redirects on ack.
  always_comb begin
    w_state_nxt   = r_state;
    w_mem_stall   = 1'b0;
    w_redirect    = 1'b0;
    w_lu_stall    = 1'b0;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    pc_sel_branch = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    mem_wb_flush  = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (w_mem_op && !dmem_ack) begin
          w_mem_stall = 1'b1;
          w_state_nxt = ST_MEM_WAIT;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ack) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_mem_stall = 1'b1;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase

    if (w_mem_stall) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (ex_mem_br_taken) begin
      w_redirect    = 1'b1;
      pc_sel_branch = 1'b1;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      ex_mem_flush  = 1'b1;
    end else if (w_load_use) begin
      w_lu_stall  = 1'b1;
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  // The timer saturates at MEM_TIMEOUT; the flag only reports, it never
  // forces the wait to end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer       <= '0;
      r_mem_timeout <= 1'b0;
    end else if ((r_state == ST_MEM_WAIT) && !dmem_ack) begin
      if (r_timer != c_TMO_MAX) begin
        r_timer <= r_timer + c_TMR_ONE;
      end
      if (r_timer >= c_TMO_LAST) begin
        r_mem_timeout <= 1'b1;
      end
    end else if (w_state_nxt == ST_RUN) begin
      r_timer <= '0;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_mem_stall | w_lu_stall),
    .count (stall_cnt)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_redirect),
    .count (flush_cnt)
  );

  // Gating with reset makes the request drop the moment reset is applied.
  assign dmem_req    = w_mem_op & ~reset;
  assign mem_timeout = r_mem_timeout;
  assign ctrl_state  = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_pipeline_hazard_ctrl : directed + random bench with a reference model   |
// | Rev 1.0                 : initial release                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam int MT    = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [3:0]       if_id_rn = '0, if_id_rm = '0, id_ex_rd = '0;
  logic             if_id_rn_vld = 1'b0, if_id_rm_vld = 1'b0, id_ex_mem_read = 1'b0;
  logic             ex_mem_mem_rd = 1'b0, ex_mem_mem_wr = 1'b0, ex_mem_br_taken = 1'b0;
  logic             dmem_ack = 1'b0;
  logic             dmem_req, pc_en, pc_sel_branch, if_id_en, if_id_flush;
  logic             id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush, mem_wb_flush;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             mem_timeout, ctrl_state;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MT)) dut (
    .clk(clk), .reset(reset),
    .if_id_rn(if_id_rn), .if_id_rm(if_id_rm),
    .if_id_rn_vld(if_id_rn_vld), .if_id_rm_vld(if_id_rm_vld),
    .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
    .ex_mem_mem_rd(ex_mem_mem_rd), .ex_mem_mem_wr(ex_mem_mem_wr),
    .ex_mem_br_taken(ex_mem_br_taken), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req), .pc_en(pc_en), .pc_sel_branch(pc_sel_branch),
    .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
    .ex_mem_en(ex_mem_en), .ex_mem_flush(ex_mem_flush),
    .mem_wb_flush(mem_wb_flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .mem_timeout(mem_timeout), .ctrl_state(ctrl_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: "waiting" means the previous cycle was a memory stall.
  bit m_wait;
  int m_stall, m_flush, m_timer;
  bit m_tmo;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    m_wait = 0; m_stall = 0; m_flush = 0; m_timer = 0; m_tmo = 0;
  endtask

  task automatic quiet();
    if_id_rn = '0; if_id_rm = '0; id_ex_rd = '0;
    if_id_rn_vld = 0; if_id_rm_vld = 0; id_ex_mem_read = 0;
    ex_mem_mem_rd = 0; ex_mem_mem_wr = 0; ex_mem_br_taken = 0; dmem_ack = 0;
  endtask

  // One cycle: compare outputs at negedge against the model, then advance it.
  task automatic step(input string tag);
    bit mem_op, stall, redirect, hz, lu, front;
    logic [11:0] exp_v, obs_v;
    mem_op   = ex_mem_mem_rd | ex_mem_mem_wr;
    stall    = m_wait ? !dmem_ack : (mem_op && !dmem_ack);
    redirect = !stall && ex_mem_br_taken;
    hz       = id_ex_mem_read && (id_ex_rd != 0) &&
               ((if_id_rn_vld && if_id_rn == id_ex_rd) || (if_id_rm_vld && if_id_rm == id_ex_rd));
    lu       = !stall && !redirect && hz;
    front    = stall || lu;
    exp_v = {mem_op, !front, redirect, !front, redirect, !stall,
             redirect || lu, !stall, redirect, stall, m_tmo, m_wait};
    @(negedge clk);
    obs_v = {dmem_req, pc_en, pc_sel_branch, if_id_en, if_id_flush, id_ex_en,
             id_ex_flush, ex_mem_en, ex_mem_flush, mem_wb_flush, mem_timeout, ctrl_state};
    chk({tag, ".outs"}, 32'(obs_v), 32'(exp_v));
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
    chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(m_flush));
    @(posedge clk);
    if (front && m_stall < CMAX) m_stall++;
    if (redirect && m_flush < CMAX) m_flush++;
    if (m_wait && !dmem_ack) begin
      if (m_timer < MT) m_timer++;
      if (m_timer >= MT) m_tmo = 1;
    end else if (!stall) begin
      m_timer = 0;
    end
    m_wait = stall;
    #1;
  endtask

  task automatic do_reset();
    quiet();
    reset = 1;
    @(posedge clk); #1;
    chk("rst.stall_cnt", 32'(stall_cnt), 0);
    chk("rst.flush_cnt", 32'(flush_cnt), 0);
    chk("rst.state", 32'(ctrl_state), 0);
    @(negedge clk) reset = 0;
    model_clear();
    @(posedge clk); #1;
  endtask

  bit hold_op;

  initial begin
    model_clear();
    do_reset();

    // quiet pipeline
    step("quiet"); step("quiet");

    // load-use on Rn
    id_ex_mem_read = 1; id_ex_rd = 4'd3; if_id_rn = 4'd3; if_id_rn_vld = 1;
    step("lu");
    quiet(); step("lu_after");
    chk("lu.stall_cnt_is_1", 32'(stall_cnt), 1);

    // single taken branch
    ex_mem_br_taken = 1; step("br");
    quiet(); step("br_after");
    chk("br.flush_cnt_is_1", 32'(flush_cnt), 1);

    // load-use on r0 is not a hazard
    id_ex_mem_read = 1; id_ex_rd = 4'd0; if_id_rm = 4'd0; if_id_rm_vld = 1;
    step("lu_r0"); quiet();

    // 4-cycle memory wait
    do_reset();
    ex_mem_mem_rd = 1;
    for (int i = 0; i < 4; i++) step("mw");
    dmem_ack = 1; step("mw_ack");
    quiet(); step("mw_after");
    chk("mw.stall_cnt_is_4", 32'(stall_cnt), 4);

    // timeout: ack withheld 10 cycles
    do_reset();
    ex_mem_mem_wr = 1;
    for (int i = 0; i < 10; i++) step("tmo");
    dmem_ack = 1; step("tmo_ack");
    quiet(); step("tmo_after");
    chk("tmo.sticky", 32'(mem_timeout), 1);

    // illegal slot: wait, then one redirect on the ack cycle
    do_reset();
    ex_mem_mem_rd = 1; ex_mem_br_taken = 1;
    step("ill"); step("ill");
    dmem_ack = 1; step("ill_ack");
    quiet(); step("ill_after");

    // branch together with load-use: redirect only
    id_ex_mem_read = 1; id_ex_rd = 4'd5; if_id_rm = 4'd5; if_id_rm_vld = 1;
    ex_mem_br_taken = 1;
    step("br_lu");
    quiet(); step("br_lu_after");

    // asynchronous reset during a wait
    ex_mem_mem_rd = 1;
    step("arst"); step("arst");
    reset = 1; #1;
    chk("arst.dmem_req", 32'(dmem_req), 0);
    chk("arst.state", 32'(ctrl_state), 0);
    chk("arst.stall_cnt", 32'(stall_cnt), 0);
    quiet();
    @(negedge clk) reset = 0;
    model_clear();
    @(posedge clk); #1;

    // randomized traffic
    hold_op = 0;
    for (int i = 0; i < 600; i++) begin
      if (!m_wait) begin
        ex_mem_mem_rd = ($urandom_range(0, 99) < 12);
        ex_mem_mem_wr = !ex_mem_mem_rd && ($urandom_range(0, 99) < 8);
        ex_mem_br_taken = (ex_mem_mem_rd | ex_mem_mem_wr) ? ($urandom_range(0, 99) < 3)
                                                          : ($urandom_range(0, 99) < 15);
      end
      dmem_ack       = ($urandom_range(0, 99) < 30);
      id_ex_mem_read = $urandom_range(0, 1);
      id_ex_rd       = 4'($urandom_range(0, 3));
      if_id_rn       = 4'($urandom_range(0, 3));
      if_id_rm       = 4'($urandom_range(0, 3));
      if_id_rn_vld   = $urandom_range(0, 1);
      if_id_rm_vld   = $urandom_range(0, 1);
      step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
